mem_rr_arbiter: RTL

- Parametrised N-channel memory arbiter; successor to the single-controller mem interface.
- Multiplexes NUM_CH controller-side request ports (read/write/address/wdata/byte_enable, resp/rdata handshake) onto one device-side port of the same protocol.
- Round-robin fairness, registered device outputs, one transaction outstanding at a time.
- Sits between core/cache controllers and the shared memory device or model.

---
 rtl/mem_rr_arbiter.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: NUM_CH-channel round-robin arbiter onto one memory device port.
// One transaction in flight; device-side outputs, ch_resp and ch_rdata are registered.
// Define MEM_ARB_ERRCHK_EN to enable the sticky protocol checker and the BUSY timeout.
module mem_rr_arbiter #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_read,
  input  logic [NUM_CH-1:0]            ch_write,
  input  logic [NUM_CH*ADDR_W-1:0]     ch_address,
  input  logic [NUM_CH*DATA_W-1:0]     ch_wdata,
  input  logic [NUM_CH*(DATA_W/8)-1:0] ch_byte_enable,
  output logic [NUM_CH-1:0]            ch_resp,
  output logic [DATA_W-1:0]            ch_rdata,
  output logic                         dev_read,
  output logic                         dev_write,
  output logic [ADDR_W-1:0]            dev_address,
  output logic [DATA_W-1:0]            dev_wdata,
  output logic [DATA_W/8-1:0]          dev_byte_enable,
  input  logic                         dev_resp,
  input  logic [DATA_W-1:0]            dev_rdata,
  output logic [15:0]                  errcode,
  output logic                         halt
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned SUM_W = PTR_W + 1;

  // Reject configurations outside the supported range at elaboration
  if (NUM_CH < 1 || NUM_CH > 16 || TIMEOUT_CYC < 1 || (DATA_W % 8) != 0) begin : g_bad_cfg
    $error("mem_rr_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state, state_d;
  logic [PTR_W-1:0]    ptr, ptr_d, grant, grant_d;
  logic [NUM_CH-1:0]   req, ch_resp_d;
  logic [DATA_W-1:0]   ch_rdata_d, dev_wdata_d;
  logic                dev_read_d, dev_write_d;
  logic [ADDR_W-1:0]   dev_address_d;
  logic [BE_W-1:0]     dev_byte_enable_d;
  logic [ADDR_W-1:0]   addr_a [NUM_CH];
  logic [DATA_W-1:0]   wdata_a [NUM_CH];
  logic [BE_W-1:0]     be_a [NUM_CH];
  logic                found;
  logic [PTR_W-1:0]    arb_idx, nxt_ptr;
  logic [SUM_W-1:0]    arb_sum, nxt_sum;

  assign req = ch_read | ch_write;

  // Unpack flat channel buses into per-channel arrays
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      addr_a[i]  = ch_address[i*ADDR_W +: ADDR_W];
      wdata_a[i] = ch_wdata[i*DATA_W +: DATA_W];
      be_a[i]    = ch_byte_enable[i*BE_W +: BE_W];
    end
  end

  // Round-robin search starting at ptr, wrapping modulo NUM_CH
  always_comb begin
    found   = 1'b0;
    arb_idx = '0;
    arb_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      arb_sum = {1'b0, ptr} + SUM_W'(i);
      if (arb_sum >= SUM_W'(NUM_CH)) arb_sum = arb_sum - SUM_W'(NUM_CH);
      if (!found && req[PTR_W'(arb_sum)]) begin
        found   = 1'b1;
        arb_idx = PTR_W'(arb_sum);
      end
    end
    nxt_sum = {1'b0, arb_idx} + SUM_W'(1);
    nxt_ptr = (nxt_sum >= SUM_W'(NUM_CH)) ? '0 : PTR_W'(nxt_sum);
  end

`ifdef MEM_ARB_ERRCHK_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] tmo_cnt, tmo_cnt_d;
  logic             tmo_hit;
  logic [3:0]       err_new;
  logic [15:0]      errcode_d;
  logic             rw_hit;
  logic [PTR_W-1:0] rw_ch;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d           = state;
    ptr_d             = ptr;
    grant_d           = grant;
    dev_read_d        = dev_read;
    dev_write_d       = dev_write;
    dev_address_d     = dev_address;
    dev_wdata_d       = dev_wdata;
    dev_byte_enable_d = dev_byte_enable;
    ch_resp_d         = '0;
    ch_rdata_d        = ch_rdata;
`ifdef MEM_ARB_ERRCHK_EN
    tmo_cnt_d         = tmo_cnt;
    tmo_hit           = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          grant_d           = arb_idx;
          ptr_d             = nxt_ptr;
          dev_address_d     = addr_a[arb_idx];
          dev_wdata_d       = wdata_a[arb_idx];
          dev_byte_enable_d = be_a[arb_idx];
          dev_write_d       = ch_write[arb_idx];
          dev_read_d        = ~ch_write[arb_idx];
          state_d           = BUSY;
`ifdef MEM_ARB_ERRCHK_EN
          tmo_cnt_d         = '0;
`endif
        end
      end
      BUSY: begin
        if (dev_resp) begin
          dev_read_d  = 1'b0;
          dev_write_d = 1'b0;
          ch_rdata_d  = dev_rdata;
          ch_resp_d   = NUM_CH'(1) << grant;
          state_d     = RESP;
        end
`ifdef MEM_ARB_ERRCHK_EN
        else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          dev_read_d  = 1'b0;
          dev_write_d = 1'b0;
          ch_rdata_d  = '0;
          ch_resp_d   = NUM_CH'(1) << grant;
          tmo_hit     = 1'b1;
          state_d     = RESP;
        end else begin
          tmo_cnt_d   = tmo_cnt + CNT_W'(1);
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, pointer and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= '0;
      grant           <= '0;
      dev_read        <= 1'b0;
      dev_write       <= 1'b0;
      dev_address     <= '0;
      dev_wdata       <= '0;
      dev_byte_enable <= '0;
      ch_resp         <= '0;
      ch_rdata        <= '0;
    end else begin
      state           <= state_d;
      ptr             <= ptr_d;
      grant           <= grant_d;
      dev_read        <= dev_read_d;
      dev_write       <= dev_write_d;
      dev_address     <= dev_address_d;
      dev_wdata       <= dev_wdata_d;
      dev_byte_enable <= dev_byte_enable_d;
      ch_resp         <= ch_resp_d;
      ch_rdata        <= ch_rdata_d;
    end
  end

`ifdef MEM_ARB_ERRCHK_EN
  // Protocol error detection; first error records its channel index
  always_comb begin
    rw_hit = 1'b0;
    rw_ch  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rw_hit && ch_read[i] && ch_write[i]) begin
        rw_hit = 1'b1;
        rw_ch  = PTR_W'(i);
      end
    end
    err_new    = '0;
    err_new[0] = rw_hit;
    if (state == BUSY) begin
      err_new[1] = ~req[grant];
      err_new[2] = (addr_a[grant] != dev_address) || (wdata_a[grant] != dev_wdata) ||
                   (be_a[grant] != dev_byte_enable);
    end
    err_new[3] = tmo_hit;
    errcode_d       = errcode;
    errcode_d[3:0]  = errcode[3:0] | err_new;
    if ((errcode[3:0] == 4'h0) && (err_new != 4'h0))
      errcode_d[15:8] = rw_hit ? 8'(rw_ch) : 8'(grant);
  end

  // Sticky error code, halt flag and BUSY timeout counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      errcode <= '0;
      halt    <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      errcode <= errcode_d;
      halt    <= |errcode_d;
      tmo_cnt <= tmo_cnt_d;
    end
  end
`else
  assign errcode = '0;
  assign halt    = 1'b0;
`endif

endmodule
